// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with byte enables, bypass and reset clear sweep
// Clear FSM walks the array after reset; writes are only taken in RUN.
// Reads are combinational with optional zero register and same-cycle write forwarding.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W/8-1:0]      wbe_i,
  input  logic [N_RD*ADDR_W-1:0]   raddr_i,
  output logic [N_RD*DATA_W-1:0]   rdata_o,
  output logic                     ready_o,
  output logic                     wr_drop_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  // Entry 0 is never stored when it is the hard-wired zero, so the sweep skips it.
  localparam logic [ADDR_W-1:0] CLR_START = ADDR_W'(ZERO_REG != 0 ? 1 : 0);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_we;
  logic              wr_drop_q;
  logic              wr_en;
  logic [DATA_W-1:0] wmerge;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear sweep next-state: zero one entry per edge until the last address is done.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    if (state_q == S_CLEAR) begin
      clr_we = 1'b1;
      if (clr_ptr_q == CLR_LAST) begin
        state_d = S_RUN;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
  end

  // FSM, sweep pointer and the dropped-write pulse; a request during CLEAR is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= CLR_START;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_drop_q <= (state_q == S_CLEAR) && we_i;
    end
  end

  // Byte-merged write word: enabled bytes from wdata, the rest from the current entry.
  always_comb begin
    wmerge = '0;
    for (int b = 0; b < NB; b++) begin
      wmerge[b*8 +: 8] = wbe_i[b] ? wdata_i[b*8 +: 8] : mem_q[waddr_i][b*8 +: 8];
    end
  end

  // Writes to the zero register are swallowed without flagging a drop.
  always_comb begin
    wr_en = (state_q == S_RUN) && we_i && !((ZERO_REG != 0) && (waddr_i == '0));
  end

  // Single array writer: the sweep owns the port in CLEAR, the write path in RUN.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clr_we) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_en) begin
        mem_q[waddr_i] <= wmerge;
      end
    end
  end

  // Per-port read mux in priority order: not ready, zero register, bypass, array.
  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < N_RD; p++) begin
      if (state_q == S_RUN && !rst_i) begin
        if ((ZERO_REG != 0) && (raddr_i[p*ADDR_W +: ADDR_W] == '0)) begin
          rdata_o[p*DATA_W +: DATA_W] = '0;
        end else if ((BYPASS != 0) && we_i && (waddr_i == raddr_i[p*ADDR_W +: ADDR_W])) begin
          rdata_o[p*DATA_W +: DATA_W] = wmerge;
        end else begin
          rdata_o[p*DATA_W +: DATA_W] = mem_q[raddr_i[p*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  assign ready_o   = (state_q == S_RUN);
  assign wr_drop_o = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed bench for regfile_mp with a behavioural reference model
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [9:0]  raddr;

  logic [63:0] rd [3];
  logic        rdy [3];
  logic        drp [3];

  // Instance 0: defaults. Instance 1: no bypass. Instance 2: no zero register.
  localparam int ZR [3] = '{1, 1, 0};
  localparam int BP [3] = '{1, 0, 1};

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(1), .BYPASS(1)) u_a (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .raddr_i(raddr), .rdata_o(rd[0]), .ready_o(rdy[0]), .wr_drop_o(drp[0]));
  regfile_mp #(.ZERO_REG(1), .BYPASS(0)) u_b (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .raddr_i(raddr), .rdata_o(rd[1]), .ready_o(rdy[1]), .wr_drop_o(drp[1]));
  regfile_mp #(.ZERO_REG(0), .BYPASS(1)) u_c (
    .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .raddr_i(raddr), .rdata_o(rd[2]), .ready_o(rdy[2]), .wr_drop_o(drp[2]));

  // Reference model: contents, cleared flag, clear edges seen, pending drop pulse.
  logic [31:0] mm [3][32];
  bit          run_m [3];
  int          cnt_m [3];
  bit          drop_m [3];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
    if (rst || !run_m[i]) return 32'h0;
    if (ZR[i] != 0 && a == 5'd0) return 32'h0;
    if (BP[i] != 0 && we && waddr == a) return merge(mm[i][a], wdata, wbe);
    return mm[i][a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // The sweep takes DEPTH-ZR edges and clears entries ZR..31 in order.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        run_m[i]  = 1'b0;
        cnt_m[i]  = 0;
        drop_m[i] = 1'b0;
      end else if (!run_m[i]) begin
        mm[i][ZR[i] + cnt_m[i]] = 32'h0;
        cnt_m[i]++;
        if (cnt_m[i] == 32 - ZR[i]) run_m[i] = 1'b1;
        drop_m[i] = we;
      end else begin
        drop_m[i] = 1'b0;
        if (we && !(ZR[i] != 0 && waddr == 5'd0)) mm[i][waddr] = merge(mm[i][waddr], wdata, wbe);
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  always begin
    @(negedge clk);
    #3;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ready[%0d]", i), {31'h0, rdy[i]}, {31'h0, run_m[i]});
        chk($sformatf("wr_drop[%0d]", i), {31'h0, drp[i]}, {31'h0, drop_m[i]});
        chk($sformatf("rdata0[%0d]", i), rd[i][31:0], exp_rd(i, raddr[4:0]));
        chk($sformatf("rdata1[%0d]", i), rd[i][63:32], exp_rd(i, raddr[9:5]));
      end
    end
  end

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [4:0] r0, input logic [4:0] r1);
    we = w; waddr = wa; wdata = wd; wbe = be; raddr = {r1, r0};
  endtask

  // Release reset and step up to 40 edges, recording when each instance turns ready.
  // Optionally raise a write to address 3 before clear edge drop_edge.
  task automatic sweep(input int drop_edge, output int ea, output int ec);
    ea = 0; ec = 0;
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      drive(e == drop_edge, 5'd3, 32'h0000DEAD, 4'hF, 5'd0, 5'd0);
      @(posedge clk); #1;
      if (rdy[0] && ea == 0) ea = e;
      if (rdy[2] && ec == 0) ec = e;
      if (drop_edge > 0 && e == drop_edge)     chk("drop_pulse_hi", {31'h0, drp[0]}, 32'd1);
      if (drop_edge > 0 && e == drop_edge + 1) chk("drop_pulse_lo", {31'h0, drp[0]}, 32'd0);
      @(negedge clk);
    end
  endtask

  int ea, ec;

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("reset_ready", {31'h0, rdy[0]}, 32'd0);
    chk("reset_drop", {31'h0, drp[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);

    // Reset sweep with defaults: ready after 31 edges, 32 without the zero register.
    sweep(0, ea, ec);
    chk("sweep_edges_zr1", ea, 31);
    chk("sweep_edges_zr0", ec, 32);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 4'h0, 5'(a), 5'(31 - a));
      #2;
      chk("clear_port0", rd[0][31:0], 32'h0);
      chk("clear_port1", rd[0][63:32], 32'h0);
      @(negedge clk);
    end

    // Byte-enable merge at address 5.
    drive(1'b1, 5'd5, 32'hAABBCCDD, 4'b1111, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h11223344, 4'b0101, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
    #2;
    for (int i = 0; i < 3; i++) chk($sformatf("byte_merge[%0d]", i), rd[i][31:0], 32'hAA22CC44);
    @(negedge clk);

    // Same-cycle forwarding, absent when BYPASS=0.
    drive(1'b1, 5'd7, 32'h12345678, 4'b1111, 5'd7, 5'd5);
    #2;
    chk("bypass_on", rd[0][31:0], 32'h12345678);
    chk("bypass_off", rd[1][31:0], 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7);
    #2;
    chk("after_write_nobypass", rd[1][31:0], 32'h12345678);
    @(negedge clk);

    // Zero register swallows writes; with ZERO_REG=0 entry 0 is ordinary storage.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
    #2;
    chk("zero_same_cycle", rd[0][31:0], 32'h0);
    chk("zr0_bypass", rd[2][31:0], 32'hFFFFFFFF);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
    #2;
    chk("zero_port0", rd[0][31:0], 32'h0);
    chk("zero_port1", rd[0][63:32], 32'h0);
    chk("zero_no_drop", {31'h0, drp[0]}, 32'd0);
    chk("zr0_readback", rd[2][31:0], 32'hFFFFFFFF);
    @(negedge clk);

    // Fill 1..4, then a one-edge reset mid-run.
    for (int a = 1; a <= 4; a++) begin
      drive(1'b1, 5'(a), 32'h100 + 32'(a), 4'hF, 5'd0, 5'd0);
      @(negedge clk);
    end
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd4);
    #2;
    chk("fill_readback", rd[0][31:0], 32'h103);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_reads_zero", rd[0][63:32], 32'h0);
    @(posedge clk); #1;
    chk("rst_ready_drop", {31'h0, rdy[0]}, 32'd0);
    @(negedge clk);

    // Repeat sweep with a write raised before the 10th clear edge.
    sweep(10, ea, ec);
    chk("resweep_edges", ea, 31);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd4);
    #2;
    for (int i = 0; i < 3; i++) chk($sformatf("dropped_addr3[%0d]", i), rd[i][31:0], 32'h0);
    chk("cleared_addr4", rd[0][63:32], 32'h0);
    @(negedge clk);
    @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the single-cycle RISC-V core and its successors. It has configurable data width, depth and read-port count. Writes use per-byte enables and an optional write-to-read bypass, and entry 0 can be a hard-wired zero. Reset starts a sequential clear sweep with a `ready` indication. The block sits between instruction decode (read addresses) and writeback (write port).

## Interface
- `DATA_W`, default 32: entry width in bits; must be a multiple of 8.
- `ADDR_W`, default 5: address width; `DEPTH = 2**ADDR_W`.
- `N_RD`, default 2: number of combinational read ports (1..4).
- `ZERO_REG`, default 1: 1 means entry 0 always reads 0 and ignores writes.
- `BYPASS`, default 1: 1 means a same-cycle write is forwarded to matching read ports.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `we` input 1: write request.
- `waddr` input ADDR_W: write address.
- `wdata` input DATA_W: write data.
- `wbe` input DATA_W/8: byte enables; bit b covers `wdata[8b+7:8b]`.
- `raddr` input N_RD*ADDR_W: flattened read addresses; port p occupies `[p*ADDR_W +: ADDR_W]`.
- `rdata` output N_RD*DATA_W: flattened read data, same packing as `raddr`.
- `ready` output 1: high when the array is cleared and accepting writes.
- `wr_drop` output 1: registered one-cycle pulse flagging a write request that was discarded.

## Operation
**Clear FSM.** Two states, CLEAR and RUN; pointer `clr_ptr` is ADDR_W bits.
- Any edge with `rst`=1: state goes to CLEAR; `clr_ptr` loads `ZERO_REG ? 1 : 0`; `ready`=0; `wr_drop`=0; no array write.
- CLEAR, `rst`=0: write 0 to `clr_ptr`, then increment it. The edge that clears `DEPTH-1` moves the state to RUN and sets `ready`=1.
- RUN: stays in RUN until `rst`.
- Reset asserted mid-sweep: the sweep restarts from the start value; entries already cleared stay cleared.

**Write path.** Applies in RUN only.
- When `we`=1, each byte b with `wbe[b]`=1 is updated at `waddr`; other bytes keep their value.
- `wbe`=0 with `we`=1 is a legal no-op and does not raise `wr_drop`.
- With `ZERO_REG`=1 and `waddr`=0, the write is ignored silently, with no `wr_drop`.

**Dropped writes.** A `we`=1 sampled in CLEAR with `rst`=0 is discarded. `wr_drop`=1 for the following cycle only.

**Read path.** Combinational, per port p, in priority order:
1. state CLEAR, or `rst`=1: 0.
2. `ZERO_REG`=1 and `raddr_p`=0: 0.
3. `BYPASS`=1 and `we`=1 and `waddr`=`raddr_p`: the byte-merged value that the current edge will store. Bytes with `wbe`=0 come from the array.
4. Otherwise: array contents at `raddr_p`.

All N_RD ports are independent. Any subset may share an address; each returns the same value.

**Width rules.**
- No arithmetic on data.
- `clr_ptr` reaching `DEPTH-1` is the terminal compare; the pointer never wraps through 0 in CLEAR.
- The array is exactly `DEPTH` entries (0..DEPTH-1).

## Timing
**Reset values.**
- `ready`=0 and `wr_drop`=0.
- `rdata`=0 on all ports while `rst`=1 and throughout CLEAR.

**Clear latency.**
- The first edge with `rst`=0 clears the first entry.
- `ready` rises after `DEPTH-ZERO_REG` such edges: 31 edges for the defaults, 32 with `ZERO_REG`=0.
- A write is accepted on the first edge where `ready` is already 1.

**Read/write timing.**
- Read latency is 0 cycles (combinational).
- A written value is visible from the array on the cycle after the write edge.
- With `BYPASS`=1 it is also visible in the same cycle; with `BYPASS`=0 it is not.
- A simultaneous write and read of the same address with `BYPASS`=0 returns the old value.

**wr_drop timing.** It rises one edge after the dropped request and falls the next edge, unless the next request is dropped too.

## Test plan
- Reset sweep: `rst`=1 for 2 edges, then 0 with defaults. `ready` is 0 for exactly 31 edges, then 1. All 32 entries read 0 on both ports.
- Byte-enable write: write `waddr`=5, `wdata`=0xAABBCCDD, `wbe`=1111; then `wdata`=0x11223344, `wbe`=0101. Next cycle `raddr`=5 returns 0xAA22CC44.
- Bypass: with `BYPASS`=1, `we`=1, `waddr`=`raddr_0`=7, `wdata`=0x12345678, `wbe`=1111. `rdata_0`=0x12345678 in the same cycle. Rerun with `BYPASS`=0: the old value (0) is returned.
- Zero register: write 0xFFFFFFFF to address 0. Both ports read 0 and `wr_drop` stays 0. With `ZERO_REG`=0 the same write reads back 0xFFFFFFFF.
- Dropped write: assert `we` (`waddr`=3, 0xDEAD) at the 10th clear edge. `wr_drop`=1 for exactly one cycle, and after `ready` address 3 reads 0.
- Reset mid-run: fill addresses 1..4, assert `rst` for 1 edge. All reads are 0 immediately, `ready` drops, and the full 31-edge sweep repeats.
